// File: rtl/fsm_rx_cmd.sv
// fsm_rx_cmd: command-frame receiver on the host-to-board UART direction.
// Assembles HDR, CMD, ARG_H, ARG_L (+ CHK) from the UART byte stream, then
// starts the acquire FSM on cmd 8'h01 and waits for its end-of-acquisition
// handshake, or just latches the argument on cmd 8'h02.
//
// Optional feature macro: FSM_RX_CMD_CHECKSUM_EN adds a 5th byte CHK that
// must equal CMD ^ ARG_H ^ ARG_L.
//
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   rx_data_i  received byte, qualified by rx_dv_i
//   rx_dv_i    1-cycle strobe per received byte
//   eoa_i      end-of-acquisition level (1 = idle, 0 = acquiring)
//   sta_o      1-cycle start pulse to the acquire FSM
//   cmd_o      last accepted command byte
//   arg_o      last accepted argument {arg_h, arg_l}
//   busy_o     high from header accepted until back in IDLE
//   done_o     1-cycle pulse when a started acquisition completes
//   err_o      1-cycle pulse on a frame error (bad cmd, checksum, timeout)
module fsm_rx_cmd #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_dv_i,
    input  logic        eoa_i,
    output logic        sta_o,
    output logic [7:0]  cmd_o,
    output logic [15:0] arg_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [7:0] CMD_ACQ = 8'h01;
    localparam logic [7:0] CMD_CFG = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ARGH = 3'd2,
        ST_ARGL = 3'd3,
`ifdef FSM_RX_CMD_CHECKSUM_EN
        ST_CHK  = 3'd4,
`endif
        ST_EXEC = 3'd5,
        ST_WLO  = 3'd6,
        ST_WHI  = 3'd7
    } state_t;

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [7:0]  frm_cmd, frm_cmd_d;
    logic [7:0]  frm_argh, frm_argh_d;
`ifdef FSM_RX_CMD_CHECKSUM_EN
    logic [7:0]  frm_argl, frm_argl_d;
`endif
    logic        sta_d, busy_d, done_d, err_d;
    logic [7:0]  cmd_d;
    logic [15:0] arg_d;
    logic        exec_go;
    logic [15:0] exec_arg;
    logic        tmo;

    // Inter-byte timeout reached on this edge (a simultaneous byte still wins)
    assign tmo = (cnt == (TIMEOUT_CYC - 16'd1));

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cnt      <= 16'h0000;
            frm_cmd  <= 8'h00;
            frm_argh <= 8'h00;
`ifdef FSM_RX_CMD_CHECKSUM_EN
            frm_argl <= 8'h00;
`endif
            sta_o    <= 1'b0;
            cmd_o    <= 8'h00;
            arg_o    <= 16'h0000;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            frm_cmd  <= frm_cmd_d;
            frm_argh <= frm_argh_d;
`ifdef FSM_RX_CMD_CHECKSUM_EN
            frm_argl <= frm_argl_d;
`endif
            sta_o    <= sta_d;
            cmd_o    <= cmd_d;
            arg_o    <= arg_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            err_o    <= err_d;
        end
    end

    // Next-state and next-output logic. The EXEC decision is taken on the
    // edge that accepts the last frame byte so sta_o appears in the EXEC cycle.
    always_comb begin
        state_d    = state;
        cnt_d      = 16'h0000;
        frm_cmd_d  = frm_cmd;
        frm_argh_d = frm_argh;
`ifdef FSM_RX_CMD_CHECKSUM_EN
        frm_argl_d = frm_argl;
`endif
        sta_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cmd_d      = cmd_o;
        arg_d      = arg_o;
        exec_go    = 1'b0;
        exec_arg   = 16'h0000;

        case (state)
            ST_IDLE: begin
                if (rx_dv_i && (rx_data_i == HDR_BYTE)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_dv_i) begin
                    frm_cmd_d = rx_data_i;
                    state_d   = ST_ARGH;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            ST_ARGH: begin
                if (rx_dv_i) begin
                    frm_argh_d = rx_data_i;
                    state_d    = ST_ARGL;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            ST_ARGL: begin
                if (rx_dv_i) begin
`ifdef FSM_RX_CMD_CHECKSUM_EN
                    frm_argl_d = rx_data_i;
                    state_d    = ST_CHK;
`else
                    exec_go  = 1'b1;
                    exec_arg = {frm_argh, rx_data_i};
`endif
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
`ifdef FSM_RX_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (rx_dv_i) begin
                    if (rx_data_i == (frm_cmd ^ frm_argh ^ frm_argl)) begin
                        exec_go  = 1'b1;
                        exec_arg = {frm_argh, frm_argl};
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
`endif
            ST_EXEC: begin
                state_d = (frm_cmd == CMD_ACQ) ? ST_WLO : ST_IDLE;
            end
            ST_WLO: begin
                if (!eoa_i) begin
                    state_d = ST_WHI;
                end
            end
            ST_WHI: begin
                if (eoa_i) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Command dispatch on frame completion
        if (exec_go) begin
            state_d = ST_EXEC;
            case (frm_cmd)
                CMD_ACQ: begin
                    sta_d = 1'b1;
                    cmd_d = frm_cmd;
                    arg_d = exec_arg;
                end
                CMD_CFG: begin
                    cmd_d = frm_cmd;
                    arg_d = exec_arg;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule
